dac_source_capture: RTL and testbench

- Upstream feeder for the per-channel DAC output stage.
- Watches the deserialized amplifier word stream, one frame of channel words per sample period.
- Captures the word of the selected channel and, optionally, of a software-reference channel.
- Presents both as stable 16-bit offset-binary values (DAC_input, software_reference) with a one-cycle sample_valid strobe. Also tracks frames in which the selected channel never arrived.

---
 rtl/dac_source_capture_if.sv | 37 +++
 rtl/dac_source_capture.sv | 142 ++++++++++++++
 tb/tb_dac_source_capture.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_source_capture_if.sv
// Purpose: bundles the word stream, frame markers, channel configuration and
//          captured outputs of dac_source_capture into a single port.
// Ports:   master drives the word stream and configuration and reads the results;
//          slave is the capture block itself.
interface dac_source_capture_if #(
  parameter int MISS_W = 8
);
  // Word stream and frame markers
  logic [15:0]       word_in;
  logic              word_valid;
  logic [5:0]        word_ch;
  logic              frame_start;
  logic              frame_done;
  // Channel configuration, latched per frame
  logic [5:0]        sel_ch;
  logic [5:0]        ref_ch;
  logic              ref_en;
  logic              clear_miss;
  // Captured results
  logic [15:0]       DAC_input;
  logic [15:0]       software_reference;
  logic              sample_valid;
  logic              sel_missed;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output word_in, word_valid, word_ch, frame_start, frame_done,
    output sel_ch, ref_ch, ref_en, clear_miss,
    input  DAC_input, software_reference, sample_valid, sel_missed, miss_count
  );

  modport slave (
    input  word_in, word_valid, word_ch, frame_start, frame_done,
    input  sel_ch, ref_ch, ref_en, clear_miss,
    output DAC_input, software_reference, sample_valid, sel_missed, miss_count
  );
endinterface

// File: rtl/dac_source_capture.sv
// Purpose: captures the selected and software-reference channel words of each
//          amplifier frame and publishes them as stable offset-binary values for the DAC stage.
// Latency: frame_done in cycle N -> PUBLISH in N+1 -> new outputs and sample_valid in N+2.
// Backpressure: none; the word stream cannot be stalled, so words outside a frame are dropped.
// Ports:   dataclk/reset (async, active-high) plus bus (slave): word stream, frame markers,
//          sel/ref configuration, clear_miss in; DAC_input, software_reference,
//          sample_valid, sel_missed, miss_count out (all registered).
module dac_source_capture #(
  parameter int NUM_CH = 32,
  parameter int MISS_W = 8
) (
  input  logic                  dataclk,
  input  logic                  reset,
  dac_source_capture_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam logic [15:0]       MIDSCALE = 16'h8000;
  localparam logic [MISS_W-1:0] MISS_MAX = '1;
  localparam logic [6:0]        NUM_CH_L = 7'(NUM_CH);

  state_t            state;
  logic [5:0]        sel_q;
  logic [5:0]        ref_q;
  logic              ren_q;
  logic [15:0]       sel_shadow;
  logic [15:0]       ref_shadow;
  logic              got_sel;
  logic              got_ref;

  logic [15:0]       dac_q;
  logic [15:0]       sw_ref_q;
  logic              sample_valid_q;
  logic              sel_missed_q;
  logic [MISS_W-1:0] miss_q;

  logic              cap_win;
  logic [5:0]        cur_sel;
  logic [5:0]        cur_ref;
  logic              cur_ren;
  logic              ch_ok;
  logic              hit_sel;
  logic              hit_ref;
  logic              publish_miss;
  logic              abort;
  logic              miss_inc;

  // A frame_start cycle always opens a new frame, so its word is matched
  // against the configuration being latched in that same cycle.
  always_comb begin
    cap_win      = bus.frame_start || (state == COLLECT);
    cur_sel      = bus.frame_start ? bus.sel_ch : sel_q;
    cur_ref      = bus.frame_start ? bus.ref_ch : ref_q;
    cur_ren      = bus.frame_start ? bus.ref_en : ren_q;
    ch_ok        = bus.word_valid && ({1'b0, bus.word_ch} < NUM_CH_L);
    hit_sel      = cap_win && ch_ok && (bus.word_ch == cur_sel);
    hit_ref      = cap_win && ch_ok && cur_ren && (bus.word_ch == cur_ref);
    publish_miss = (state == PUBLISH) && !got_sel;
    abort        = (state == COLLECT) && bus.frame_start;
    miss_inc     = publish_miss || abort;
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sel_q          <= '0;
      ref_q          <= '0;
      ren_q          <= 1'b0;
      sel_shadow     <= '0;
      ref_shadow     <= '0;
      got_sel        <= 1'b0;
      got_ref        <= 1'b0;
      dac_q          <= MIDSCALE;
      sw_ref_q       <= MIDSCALE;
      sample_valid_q <= 1'b0;
      sel_missed_q   <= 1'b0;
      miss_q         <= '0;
    end else begin
      sample_valid_q <= 1'b0;

      case (state)
        IDLE:    if (bus.frame_start) state <= COLLECT;
        // frame_start outranks frame_done: the current frame is abandoned.
        COLLECT: if (!bus.frame_start && bus.frame_done) state <= PUBLISH;
        PUBLISH: state <= bus.frame_start ? COLLECT : IDLE;
        default: state <= IDLE;
      endcase

      if (bus.frame_start) begin
        sel_q      <= bus.sel_ch;
        ref_q      <= bus.ref_ch;
        ren_q      <= bus.ref_en;
        got_sel    <= 1'b0;
        got_ref    <= 1'b0;
        sel_shadow <= '0;
        ref_shadow <= '0;
      end

      // Later writes override the frame_start clear, so the opening word of
      // a frame is kept; repeated channels simply overwrite (last one wins).
      if (hit_sel) begin
        sel_shadow <= bus.word_in;
        got_sel    <= 1'b1;
      end
      if (hit_ref) begin
        ref_shadow <= bus.word_in;
        got_ref    <= 1'b1;
      end

      // Reads the pre-edge flags, so a frame_start in PUBLISH still publishes
      // the finished frame while the new one starts collecting.
      if (state == PUBLISH) begin
        if (got_sel) begin
          dac_q          <= sel_shadow;
          sample_valid_q <= 1'b1;
        end
        if (!ren_q)       sw_ref_q <= MIDSCALE;
        else if (got_ref) sw_ref_q <= ref_shadow;
      end

      if (bus.clear_miss) begin
        miss_q       <= '0;
        sel_missed_q <= 1'b0;
      end else begin
        if (miss_inc && (miss_q != MISS_MAX)) miss_q <= miss_q + 1'b1;
        if (publish_miss) sel_missed_q <= 1'b1;
      end
    end
  end

  assign bus.DAC_input          = dac_q;
  assign bus.software_reference = sw_ref_q;
  assign bus.sample_valid       = sample_valid_q;
  assign bus.sel_missed         = sel_missed_q;
  assign bus.miss_count         = miss_q;

endmodule

// File: tb/tb_dac_source_capture.sv
// Purpose: directed bench for dac_source_capture with hand-computed expectations.
// Ports:   drives the interface as master; dataclk is a free-running 10 ns clock.
module tb_dac_source_capture;

  logic dataclk = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 dataclk = ~dataclk;

  dac_source_capture_if #(.MISS_W(8)) bus ();

  dac_source_capture #(.NUM_CH(32), .MISS_W(8)) dut (
    .dataclk (dataclk),
    .reset   (reset),
    .bus     (bus)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge dataclk);
    #1;
  endtask

  // Present one cycle of word stream / frame markers, then return to idle.
  task automatic drive(input logic v, input logic [5:0] ch, input logic [15:0] d,
                       input logic fs, input logic fd);
    bus.word_valid  = v;
    bus.word_ch     = ch;
    bus.word_in     = d;
    bus.frame_start = fs;
    bus.frame_done  = fd;
    tick();
    bus.word_valid  = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_done  = 1'b0;
  endtask

  // Channels 0..31 with word base+ch, frame_done on ch31; channel 'skip' is left out.
  // Returns during the PUBLISH cycle.
  task automatic send_frame(input logic [15:0] base, input int skip);
    for (int ch = 0; ch < 32; ch++)
      drive(ch != skip, 6'(ch), base + 16'(ch), ch == 0, ch == 31);
  endtask

  task automatic pulse_clear();
    bus.clear_miss = 1'b1;
    tick();
    bus.clear_miss = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.DAC_input !== 16'h8000) begin errors++; $display("FAIL reset_dac: got %h expected 8000", bus.DAC_input); end
    checks++; if (bus.software_reference !== 16'h8000) begin errors++; $display("FAIL reset_ref: got %h expected 8000", bus.software_reference); end
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.miss_count !== 8'd0) begin errors++; $display("FAIL reset_miss: got %0d expected 0", bus.miss_count); end
    checks++; if (bus.sel_missed !== 1'b0) begin errors++; $display("FAIL reset_sel_missed: got %b expected 0", bus.sel_missed); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.sel_ch = 6'd5; bus.ref_en = 1'b0;
    send_frame(16'h1000, -1);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.DAC_input !== 16'h8000) begin errors++; $display("FAIL basic_early_dac: got %h expected 8000", bus.DAC_input); end
    tick();
    checks++; if (bus.DAC_input !== 16'h1005) begin errors++; $display("FAIL basic_dac: got %h expected 1005", bus.DAC_input); end
    checks++; if (bus.software_reference !== 16'h8000) begin errors++; $display("FAIL basic_ref: got %h expected 8000", bus.software_reference); end
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.sample_valid); end
    tick();
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.DAC_input !== 16'h1005) begin errors++; $display("FAIL basic_hold: got %h expected 1005", bus.DAC_input); end
  endtask

  task automatic test_dup_ref();
    bus.sel_ch = 6'd3; bus.ref_ch = 6'd3; bus.ref_en = 1'b1;
    drive(1'b1, 6'd3, 16'h1111, 1'b1, 1'b0);
    drive(1'b1, 6'd3, 16'hABCD, 1'b0, 1'b0);
    drive(1'b1, 6'd0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (bus.DAC_input !== 16'hABCD) begin errors++; $display("FAIL dup_dac: got %h expected abcd", bus.DAC_input); end
    checks++; if (bus.software_reference !== 16'hABCD) begin errors++; $display("FAIL dup_ref: got %h expected abcd", bus.software_reference); end
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL dup_valid: got %b expected 1", bus.sample_valid); end
    tick();
  endtask

  task automatic test_missed();
    bus.sel_ch = 6'd7; bus.ref_en = 1'b0;
    send_frame(16'h2000, -1);
    tick();
    checks++; if (bus.DAC_input !== 16'h2007) begin errors++; $display("FAIL miss_good_dac: got %h expected 2007", bus.DAC_input); end
    checks++; if (bus.software_reference !== 16'h8000) begin errors++; $display("FAIL miss_good_ref: got %h expected 8000", bus.software_reference); end
    send_frame(16'h3000, 7);
    tick();
    checks++; if (bus.DAC_input !== 16'h2007) begin errors++; $display("FAIL miss_dac_hold: got %h expected 2007", bus.DAC_input); end
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL miss_valid: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.sel_missed !== 1'b1) begin errors++; $display("FAIL miss_sticky: got %b expected 1", bus.sel_missed); end
    checks++; if (bus.miss_count !== 8'd1) begin errors++; $display("FAIL miss_count1: got %0d expected 1", bus.miss_count); end
    // Second miss with clear_miss on the increment edge.
    send_frame(16'h3000, 7);
    pulse_clear();
    checks++; if (bus.miss_count !== 8'd0) begin errors++; $display("FAIL miss_clear_count: got %0d expected 0", bus.miss_count); end
    checks++; if (bus.sel_missed !== 1'b0) begin errors++; $display("FAIL miss_clear_sticky: got %b expected 0", bus.sel_missed); end
    // Out-of-range channel is never captured, even when selected.
    bus.sel_ch = 6'd40;
    drive(1'b1, 6'd40, 16'hDEAD, 1'b1, 1'b0);
    drive(1'b1, 6'd40, 16'hBEEF, 1'b0, 1'b1);
    tick();
    checks++; if (bus.DAC_input !== 16'h2007) begin errors++; $display("FAIL range_dac: got %h expected 2007", bus.DAC_input); end
    checks++; if (bus.miss_count !== 8'd1) begin errors++; $display("FAIL range_count: got %0d expected 1", bus.miss_count); end
  endtask

  task automatic test_abort();
    pulse_clear();
    checks++; if (bus.miss_count !== 8'd0) begin errors++; $display("FAIL abort_pre_clear: got %0d expected 0", bus.miss_count); end
    bus.sel_ch = 6'd5; bus.ref_en = 1'b0;
    drive(1'b1, 6'd5, 16'h5555, 1'b1, 1'b0);
    drive(1'b1, 6'd1, 16'h0101, 1'b0, 1'b0);
    // Restart with frame_done in the same cycle: abort wins.
    drive(1'b1, 6'd0, 16'h0100, 1'b1, 1'b1);
    checks++; if (bus.miss_count !== 8'd1) begin errors++; $display("FAIL abort_count: got %0d expected 1", bus.miss_count); end
    drive(1'b1, 6'd1, 16'h0201, 1'b0, 1'b0);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL abort_no_publish: got %b expected 0", bus.sample_valid); end
    bus.sel_ch = 6'd9;
    drive(1'b1, 6'd9, 16'h9999, 1'b0, 1'b0);
    drive(1'b1, 6'd2, 16'h0202, 1'b0, 1'b1);
    tick();
    checks++; if (bus.DAC_input !== 16'h2007) begin errors++; $display("FAIL abort_dac_hold: got %h expected 2007", bus.DAC_input); end
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.miss_count !== 8'd2) begin errors++; $display("FAIL abort_count2: got %0d expected 2", bus.miss_count); end
    drive(1'b1, 6'd9, 16'h9999, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (bus.DAC_input !== 16'h9999) begin errors++; $display("FAIL sel_change_dac: got %h expected 9999", bus.DAC_input); end
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL sel_change_valid: got %b expected 1", bus.sample_valid); end
  endtask

  task automatic test_saturate();
    pulse_clear();
    bus.sel_ch = 6'd40;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 6'd0, 16'h0000, 1'b1, 1'b0);
      drive(1'b0, 6'd0, 16'h0000, 1'b0, 1'b1);
      tick();
    end
    checks++; if (bus.miss_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", bus.miss_count); end
    drive(1'b0, 6'd0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 6'd0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (bus.miss_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", bus.miss_count); end
    checks++; if (bus.DAC_input !== 16'h9999) begin errors++; $display("FAIL sat_dac: got %h expected 9999", bus.DAC_input); end
  endtask

  task automatic test_reset_mid();
    bus.sel_ch = 6'd5;
    drive(1'b1, 6'd5, 16'h7777, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checks++; if (bus.DAC_input !== 16'h8000) begin errors++; $display("FAIL rst_mid_dac: got %h expected 8000", bus.DAC_input); end
    checks++; if (bus.miss_count !== 8'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", bus.miss_count); end
    checks++; if (bus.sel_missed !== 1'b0) begin errors++; $display("FAIL rst_mid_sticky: got %b expected 0", bus.sel_missed); end
    checks++; if (bus.software_reference !== 16'h8000) begin errors++; $display("FAIL rst_mid_ref: got %h expected 8000", bus.software_reference); end
    tick();
    reset = 1'b0;
    drive(1'b1, 6'd5, 16'h6666, 1'b0, 1'b1);
    tick();
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_publish: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.DAC_input !== 16'h8000) begin errors++; $display("FAIL rst_mid_dac_after: got %h expected 8000", bus.DAC_input); end
    checks++; if (bus.miss_count !== 8'd0) begin errors++; $display("FAIL rst_mid_count_after: got %0d expected 0", bus.miss_count); end
  endtask

  task automatic test_back_to_back();
    bus.sel_ch = 6'd2; bus.ref_ch = 6'd4; bus.ref_en = 1'b1;
    drive(1'b1, 6'd2, 16'h3002, 1'b1, 1'b0);
    drive(1'b1, 6'd4, 16'h3004, 1'b0, 1'b1);
    // PUBLISH cycle doubles as the next frame_start, reference now disabled.
    bus.ref_en = 1'b0;
    drive(1'b1, 6'd2, 16'h4002, 1'b1, 1'b0);
    checks++; if (bus.DAC_input !== 16'h3002) begin errors++; $display("FAIL b2b_dac1: got %h expected 3002", bus.DAC_input); end
    checks++; if (bus.software_reference !== 16'h3004) begin errors++; $display("FAIL b2b_ref1: got %h expected 3004", bus.software_reference); end
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b expected 1", bus.sample_valid); end
    drive(1'b1, 6'd4, 16'h5004, 1'b0, 1'b1);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", bus.sample_valid); end
    tick();
    checks++; if (bus.DAC_input !== 16'h4002) begin errors++; $display("FAIL b2b_dac2: got %h expected 4002", bus.DAC_input); end
    checks++; if (bus.software_reference !== 16'h8000) begin errors++; $display("FAIL b2b_ref2: got %h expected 8000", bus.software_reference); end
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b expected 1", bus.sample_valid); end
  endtask

  initial begin
    bus.word_in     = '0;
    bus.word_valid  = 1'b0;
    bus.word_ch     = '0;
    bus.frame_start = 1'b0;
    bus.frame_done  = 1'b0;
    bus.sel_ch      = '0;
    bus.ref_ch      = '0;
    bus.ref_en      = 1'b0;
    bus.clear_miss  = 1'b0;
    test_reset();
    test_basic();
    test_dup_ref();
    test_missed();
    test_abort();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
